// File: rtl/hwpe_color_convert_stage.sv
// Job-based elastic pipeline converting NB_PIXELS 24-bit pixels per beat
// between RGB and YCbCr (or passing them through), with last/done signalling.
module hwpe_color_convert_stage #(
  parameter int unsigned NB_PIXELS    = 4,
  parameter int unsigned PIPE_STAGES  = 2,
  parameter int unsigned LEN_W        = 16,
  localparam int unsigned STREAM_WIDTH = NB_PIXELS * 24
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      clear_i,
  input  logic                      start_i,
  input  logic [1:0]                mode_i,
  input  logic [LEN_W-1:0]          len_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [STREAM_WIDTH-1:0]   in_data_i,
  input  logic [STREAM_WIDTH/8-1:0] in_strb_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [STREAM_WIDTH-1:0]   out_data_o,
  output logic [STREAM_WIDTH/8-1:0] out_strb_o,
  output logic                      out_last_o,
  output logic                      busy_o,
  output logic                      done_o
);

  localparam int unsigned SB = STREAM_WIDTH / 8;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  // Per-pixel product terms; result = base +/- ((t0+t1+t2+128) >>> 8), saturated.
  typedef struct packed {
    logic [2:0][2:0][17:0] t;
    logic [2:0][7:0]       base;
  } pix_pre_t;

  function automatic pix_pre_t f_pre(input logic [23:0] pix, input logic [1:0] mode);
    pix_pre_t p;
    logic signed [17:0] c0, c1, c2, db, dr;
    c0 = {10'd0, pix[7:0]};
    c1 = {10'd0, pix[15:8]};
    c2 = {10'd0, pix[23:16]};
    db = c1 - 18'sd128;
    dr = c2 - 18'sd128;
    p  = '0;
    case (mode)
      2'd1: begin
        p.t[0][0] = 18'sd77 * c0;
        p.t[0][1] = 18'sd150 * c1;
        p.t[0][2] = 18'sd29 * c2;
        p.t[1][0] = -18'sd43 * c0;
        p.t[1][1] = -18'sd85 * c1;
        p.t[1][2] = 18'sd128 * c2;
        p.t[2][0] = 18'sd128 * c0;
        p.t[2][1] = -18'sd107 * c1;
        p.t[2][2] = -18'sd21 * c2;
        p.base[0] = 8'd0;
        p.base[1] = 8'd128;
        p.base[2] = 8'd128;
      end
      2'd2: begin
        p.t[0][0] = 18'sd359 * dr;
        p.t[1][0] = 18'sd88 * db;
        p.t[1][1] = 18'sd183 * dr;
        p.t[2][0] = 18'sd454 * db;
        p.base[0] = pix[7:0];
        p.base[1] = pix[7:0];
        p.base[2] = pix[7:0];
      end
      default: begin
        p.base[0] = pix[7:0];
        p.base[1] = pix[15:8];
        p.base[2] = pix[23:16];
      end
    endcase
    return p;
  endfunction

  function automatic logic [23:0] f_post(input pix_pre_t p, input logic [1:0] mode);
    logic [23:0]        res;
    logic signed [17:0] s, b, v;
    res = '0;
    for (int unsigned c = 0; c < 3; c++) begin
      s = $signed(p.t[c][0]) + $signed(p.t[c][1]) + $signed(p.t[c][2]) + 18'sd128;
      s = s >>> 8;
      b = {10'd0, p.base[c]};
      // Only the green channel of YCbCr->RGB subtracts its correction term.
      v = (mode == 2'd2 && c == 1) ? b - s : b + s;
      if (v < 18'sd0)        res[8*c +: 8] = 8'd0;
      else if (v > 18'sd255) res[8*c +: 8] = 8'hFF;
      else                   res[8*c +: 8] = v[7:0];
    end
    return res;
  endfunction

  function automatic logic [STREAM_WIDTH-1:0] f_post_beat(
    input pix_pre_t [NB_PIXELS-1:0] b, input logic [1:0] mode);
    logic [STREAM_WIDTH-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < NB_PIXELS; i++) r[24*i +: 24] = f_post(b[i], mode);
    return r;
  endfunction

  state_t                         r_state;
  logic [1:0]                     r_mode;
  logic [LEN_W-1:0]               r_len, r_in_cnt, r_out_cnt;
  logic                           r_busy, r_done;
  logic [PIPE_STAGES-1:0]         r_vld;
  logic [PIPE_STAGES-1:0][SB-1:0] r_strb;
  logic [STREAM_WIDTH-1:0]        r_res;

  logic [PIPE_STAGES-1:0]         w_adv;
  logic                           w_in_ready, w_in_hs, w_out_hs;
  pix_pre_t [NB_PIXELS-1:0]       w_pre0;

  // Stage k may load when the output is consuming or any stage at/after k is empty.
  always_comb begin
    w_adv = '0;
    for (int unsigned k = 0; k < PIPE_STAGES; k++) begin
      w_adv[k] = out_ready_i;
      for (int unsigned j = k; j < PIPE_STAGES; j++)
        if (!r_vld[j]) w_adv[k] = 1'b1;
    end
  end

  always_comb begin
    w_pre0 = '0;
    for (int unsigned i = 0; i < NB_PIXELS; i++) w_pre0[i] = f_pre(in_data_i[24*i +: 24], r_mode);
  end

  assign w_in_ready = (r_state == S_RUN) && (r_in_cnt < r_len) && w_adv[0];
  assign w_in_hs    = in_valid_i && w_in_ready;
  assign w_out_hs   = r_vld[PIPE_STAGES-1] && out_ready_i;

  assign in_ready_o  = w_in_ready;
  assign out_valid_o = r_vld[PIPE_STAGES-1];
  assign out_data_o  = r_res;
  assign out_strb_o  = r_strb[PIPE_STAGES-1];
  assign out_last_o  = r_vld[PIPE_STAGES-1] && (r_out_cnt == r_len - LEN_W'(1));
  assign busy_o      = r_busy;
  assign done_o      = r_done;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_mode    <= '0;
      r_len     <= '0;
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else if (clear_i) begin
      r_state   <= S_IDLE;
      r_mode    <= '0;
      r_len     <= '0;
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            if (len_i != '0) begin
              r_state   <= S_RUN;
              r_mode    <= mode_i;
              r_len     <= len_i;
              r_in_cnt  <= '0;
              r_out_cnt <= '0;
              r_busy    <= 1'b1;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        S_RUN, S_DRAIN: begin
          if (w_in_hs) begin
            r_in_cnt <= r_in_cnt + LEN_W'(1);
            if (r_in_cnt + LEN_W'(1) == r_len) r_state <= S_DRAIN;
          end
          if (w_out_hs) begin
            r_out_cnt <= r_out_cnt + LEN_W'(1);
            if (r_out_cnt == r_len - LEN_W'(1)) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_vld  <= '0;
      r_strb <= '0;
    end else if (clear_i) begin
      r_vld  <= '0;
      r_strb <= '0;
    end else begin
      if (w_adv[0]) r_vld[0] <= w_in_hs;
      if (w_in_hs)  r_strb[0] <= in_strb_i;
      for (int unsigned k = 1; k < PIPE_STAGES; k++) begin
        if (w_adv[k]) r_vld[k] <= r_vld[k-1];
        if (w_adv[k] && r_vld[k-1]) r_strb[k] <= r_strb[k-1];
      end
    end
  end

  generate
    if (PIPE_STAGES == 1) begin : g_single
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)        r_res <= '0;
        else if (clear_i) r_res <= '0;
        else if (w_in_hs) r_res <= f_post_beat(w_pre0, r_mode);
      end
    end else begin : g_multi
      pix_pre_t [PIPE_STAGES-2:0][NB_PIXELS-1:0] r_pre;
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          r_pre <= '0;
          r_res <= '0;
        end else if (clear_i) begin
          r_pre <= '0;
          r_res <= '0;
        end else begin
          if (w_in_hs) r_pre[0] <= w_pre0;
          for (int unsigned k = 1; k < PIPE_STAGES - 1; k++)
            if (w_adv[k] && r_vld[k-1]) r_pre[k] <= r_pre[k-1];
          if (w_adv[PIPE_STAGES-1] && r_vld[PIPE_STAGES-2])
            r_res <= f_post_beat(r_pre[PIPE_STAGES-2], r_mode);
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_hwpe_color_convert_stage.sv
// Randomised bench for hwpe_color_convert_stage: beats are checked against an
// integer-arithmetic colour model, plus job timing, flags and abort behaviour.
module tb_hwpe_color_convert_stage;

  localparam int unsigned NB = 4;
  localparam int unsigned P  = 2;
  localparam int unsigned LW = 16;
  localparam int unsigned W  = NB * 24;
  localparam int unsigned SB = W / 8;

  logic          clk = 1'b0;
  logic          rst_i, clear_i, start_i;
  logic [1:0]    mode_i;
  logic [LW-1:0] len_i;
  logic          in_valid_i, in_ready_o;
  logic [W-1:0]  in_data_i;
  logic [SB-1:0] in_strb_i;
  logic          out_valid_o, out_ready_i;
  logic [W-1:0]  out_data_o;
  logic [SB-1:0] out_strb_o;
  logic          out_last_o, busy_o, done_o;

  always #5 clk = ~clk;

  hwpe_color_convert_stage #(.NB_PIXELS(NB), .PIPE_STAGES(P), .LEN_W(LW)) dut (
    .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i), .start_i(start_i),
    .mode_i(mode_i), .len_i(len_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i), .in_strb_i(in_strb_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .out_strb_o(out_strb_o), .out_last_o(out_last_o), .busy_o(busy_o), .done_o(done_o)
  );

  int n_chk = 0, n_fail = 0, cyc = 0;
  int done_cnt = 0, done_at = 0, out_beats = 0;
  int first_out_edge = 0, last_out_edge = 0, first_in_edge = 0;
  logic [W+SB-1:0] exp_q[$];
  bit              exp_last_q[$];
  logic [W-1:0]    src_q[$];
  bit              prev_stall = 0;
  logic [W+SB-1:0] prev_beat;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int fl256(input int x);
    return (x >= 0) ? x / 256 : -((-x + 255) / 256);
  endfunction

  function automatic logic [7:0] clamp8(input int x);
    return (x < 0) ? 8'd0 : (x > 255) ? 8'd255 : 8'(x);
  endfunction

  function automatic logic [23:0] ref_pix(input int mode, input logic [23:0] p);
    int a, b, c, o0, o1, o2;
    a = p[7:0]; b = p[15:8]; c = p[23:16];
    case (mode)
      1: begin
        o0 = fl256(77*a + 150*b + 29*c + 128);
        o1 = fl256(-43*a - 85*b + 128*c + 128) + 128;
        o2 = fl256(128*a - 107*b - 21*c + 128) + 128;
      end
      2: begin
        o0 = a + fl256(359*(c-128) + 128);
        o1 = a - fl256(88*(b-128) + 183*(c-128) + 128);
        o2 = a + fl256(454*(b-128) + 128);
      end
      default: begin o0 = a; o1 = b; o2 = c; end
    endcase
    return {clamp8(o2), clamp8(o1), clamp8(o0)};
  endfunction

  function automatic logic [W-1:0] ref_beat(input int mode, input logic [W-1:0] d);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < NB; i++) r[24*i +: 24] = ref_pix(mode, d[24*i +: 24]);
    return r;
  endfunction

  always @(negedge clk) begin
    #2;
    if (rst_i || clear_i) prev_stall = 0;
    else begin
      if (prev_stall) chk("stall_stable", {out_strb_o, out_data_o}, prev_beat);
      prev_stall = out_valid_o && !out_ready_i;
      prev_beat  = {out_strb_o, out_data_o};
      if (out_valid_o && out_ready_i) begin
        if (exp_q.size() == 0) chk("spurious_beat", 1, 0);
        else begin
          chk("out_beat", {out_strb_o, out_data_o}, exp_q.pop_front());
          chk("out_last", out_last_o, exp_last_q.pop_front());
        end
        if (out_beats == 0) first_out_edge = cyc + 1;
        last_out_edge = cyc + 1;
        out_beats++;
      end
      if (done_o) begin done_cnt++; done_at = cyc; end
    end
  end

  // rdy: 0 = always ready, 1 = toggling, 2 = random. abort_after>0 returns early.
  task automatic do_job(input int mode, input int len, input int offer, input int rdy,
                        input int abort_after, input int restart_at);
    int sent, done0;
    bit have, fin, busy_seen;
    logic [W-1:0]  d;
    logic [SB-1:0] s;
    done0 = done_cnt; out_beats = 0; first_in_edge = -1;
    sent = 0; have = 0; fin = 0; busy_seen = 0; d = '0; s = '0;
    @(negedge clk);
    start_i = 1'b1; mode_i = 2'(mode); len_i = LW'(len); out_ready_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    for (int t = 0; t < 600 && !fin; t++) begin
      if (t > 0) @(negedge clk);
      if (!have && sent < offer) begin
        d = (src_q.size() > 0) ? src_q.pop_front() : W'({$urandom, $urandom, $urandom});
        s = SB'($urandom);
        have = 1;
      end
      in_valid_i  = have; in_data_i = d; in_strb_i = s;
      out_ready_i = (rdy == 0) ? 1'b1 : (rdy == 1) ? 1'(t % 2) : 1'($urandom_range(0, 1));
      start_i = (t == restart_at);
      mode_i  = 2'($urandom);
      len_i   = LW'($urandom_range(1, 9));
      #1;
      if (busy_o === 1'b1) busy_seen = 1;
      if (have && in_ready_o) begin
        exp_q.push_back({s, ref_beat(mode, d)});
        exp_last_q.push_back(sent == len - 1);
        if (sent == 0) first_in_edge = cyc + 1;
        sent++;
        have = 0;
      end
      #2;
      fin = (done_cnt != done0) || (abort_after > 0 && sent == abort_after);
    end
    start_i = 1'b0;
    if (!fin) chk("job_timeout", 0, 1);
    if (abort_after == 0) begin
      chk("busy_after_done", busy_o, 0);
      repeat (2) begin
        @(negedge clk); #1;
        chk("no_accept_after_job", in_ready_o, 0);
      end
      #2;
      chk("beats_in", sent, len);
      chk("beats_out", out_beats, len);
      chk("exp_q_empty", exp_q.size(), 0);
      chk("done_once", done_cnt - done0, 1);
      if (len > 0) chk("done_timing", done_at, last_out_edge);
      if (len > 0 && rdy == 0) begin
        chk("latency", first_out_edge - first_in_edge, P);
        chk("throughput", last_out_edge - first_in_edge, len - 1 + P);
      end
      if (len == 0) chk("len0_no_busy", busy_seen, 0);
      in_valid_i = 1'b0;
    end
  endtask

  task automatic abort_job(input bit use_clear);
    int done0;
    do_job(1, 6, 6, 2, 3, -1);
    done0 = done_cnt;
    @(negedge clk);
    in_valid_i = 1'b0;
    if (use_clear) begin
      clear_i = 1'b1;
      @(negedge clk);
      clear_i = 1'b0;
    end else rst_i = 1'b1;
    #1;
    if (use_clear)
      chk("clear_outs", {out_valid_o, out_last_o, busy_o, done_o, in_ready_o, out_strb_o, out_data_o}, '0);
    else
      chk("rst_outs", {out_valid_o, out_last_o, busy_o, done_o, in_ready_o, out_strb_o, out_data_o}, '0);
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    #3;
    chk("abort_no_done", done_cnt - done0, 0);
    exp_q.delete();
    exp_last_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1; clear_i = 1'b0; start_i = 1'b0; mode_i = '0; len_i = '0;
    in_valid_i = 1'b0; in_data_i = '0; in_strb_i = '0; out_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_state", {out_valid_o, out_last_o, busy_o, done_o, in_ready_o, out_strb_o, out_data_o}, '0);
    @(negedge clk);
    rst_i = 1'b0;

    src_q.push_back({NB{24'h0000FF}});
    src_q.push_back({NB{24'hFFFFFF}});
    do_job(1, 2, 2, 0, 0, -1);

    src_q.push_back({NB{24'hFF80FF}});
    do_job(2, 1, 1, 0, 0, -1);
    src_q.push_back({NB{24'h808080}});
    do_job(2, 1, 1, 0, 0, -1);

    do_job(0, 8, 8, 1, 0, -1);
    do_job(0, 0, 2, 0, 0, -1);
    do_job(1, 4, 6, 2, 0, 2);
    do_job(2, 16, 17, 0, 0, -1);

    abort_job(1'b0);
    do_job(1, 2, 2, 0, 0, -1);
    abort_job(1'b1);
    do_job(3, 5, 5, 2, 0, -1);

    for (int j = 0; j < 4; j++)
      do_job(int'($urandom_range(0, 3)), int'($urandom_range(1, 12)), 14,
             int'($urandom_range(0, 2)), 0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hwpe_color_convert_stage.md
Name: hwpe_color_convert_stage

Overview:
- Parametrised successor to the fixed RGB-to-YCbCr converter that sits between the TCDM source and the sink in the color-converter streamer.
- Processes NB_PIXELS 24-bit pixels per beat. Supports runtime mode selection (passthrough, RGB→YCbCr, YCbCr→RGB) and a configurable elastic pipeline depth.
- Runs job-based: a start pulse carries a beat count, and the block raises last/done flags at the end of the job.

Parameters:
- NB_PIXELS, 4, pixels per stream beat; STREAM_WIDTH = NB_PIXELS*24.
- PIPE_STAGES, 2, number of registered elastic stages (1..3).
- LEN_W, 16, width of the job beat-count field.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- clear_i  in  1  synchronous flush; clears pipeline, counters and flags.
- start_i  in  1  single-cycle job start; honoured only when busy_o=0.
- mode_i  in  2  0=pass, 1=RGB→YCbCr, 2=YCbCr→RGB, 3=reserved (behaves as pass); latched on an accepted start.
- len_i  in  LEN_W  number of beats in the job; latched on an accepted start.
- in_valid_i  in  1  input beat valid.
- in_ready_o  out  1  input beat accepted when in_valid_i & in_ready_o.
- in_data_i  in  STREAM_WIDTH  pixel i at [24i+23:24i]; ch0 (R/Y)=[7:0], ch1 (G/Cb)=[15:8], ch2 (B/Cr)=[23:16].
- in_strb_i  in  STREAM_WIDTH/8  byte strobes; carried through unchanged.
- out_valid_o  out  1  output beat valid.
- out_ready_i  in  1  downstream ready.
- out_data_o  out  STREAM_WIDTH  converted beat, same packing as the input.
- out_strb_o  out  STREAM_WIDTH/8  strobes delayed with the data.
- out_last_o  out  1  high with the final beat of the job.
- busy_o  out  1  job active.
- done_o  out  1  one-cycle pulse when the final beat handshakes out.

Behaviour:
- Reset (rst_i high, async) and clear_i: busy_o, done_o, out_valid_o, out_last_o and in_ready_o are 0. out_data_o, out_strb_o, all stage valid bits and the counters are 0. mode latch = 0.
- States: IDLE, RUN, DRAIN.
  - IDLE: start_i with len_i>0 → RUN. Latch mode and len, zero the in/out counters, busy_o=1.
  - IDLE: start_i with len_i=0 → stay in IDLE, done_o pulses the next cycle, busy_o stays 0.
- RUN:
  - in_ready_o = (in_cnt < len) & stage-0 can accept.
  - Each input handshake increments in_cnt.
  - When in_cnt reaches len, go to DRAIN and drop in_ready_o.
- DRAIN: wait for output handshakes.
- Output counting and job end:
  - Each output handshake increments out_cnt.
  - out_last_o = out_valid_o & (out_cnt == len-1).
  - The handshake of the last beat pulses done_o in the following cycle, clears busy_o and returns to IDLE.
  - Out-side completion is also checked in RUN, so len=1 with a fast pipeline completes correctly.
- start_i while busy_o=1 is ignored; mode and len are not relatched.
- Elastic pipeline:
  - Stage k loads when its valid is 0 or stage k+1 (or the output, for the final stage) is consuming.
  - Zero-bubble throughput of 1 beat/cycle while out_ready_i=1.
  - Input→output latency is exactly PIPE_STAGES cycles.
  - Data and strobes hold stable while out_valid_o=1 and out_ready_i=0.
  - No combinational path from out_ready_i to out_data_o.
- Arithmetic: per pixel, unsigned 8-bit channels, signed 18-bit intermediates. ">>8" is an arithmetic shift. Every result saturates to 0..255.
  - Mode 1:
    - Y=(77R+150G+29B+128)>>8
    - Cb=((-43R-85G+128B+128)>>8)+128
    - Cr=((128R-107G-21B+128)>>8)+128
  - Mode 2, with d_b=Cb-128 and d_r=Cr-128:
    - R=Y+((359·d_r+128)>>8)
    - G=Y-((88·d_b+183·d_r+128)>>8)
    - B=Y+((454·d_b+128)>>8)
  - Mode 0/3: data unchanged.
- Arithmetic is split across stages: products in stage 0, sums/shift/saturation in the last stage. With PIPE_STAGES=1 both are done in one stage.
- Mode cannot change mid-job; it is taken from the latch only.
- Input beats offered while idle or after len beats are not accepted.
- rst_i mid-job aborts immediately with no done_o. clear_i mid-job does the same, synchronously.

Test Plan:
- Mode 1, len=2, out_ready_i=1, beat0 all pixels (255,0,0), beat1 all (255,255,255) → out pixels (77,85,255) then (255,128,128); latency 2 cycles; out_last_o on beat1; done_o one cycle after it.
- Mode 2, len=1, pixels (Y,Cb,Cr)=(255,128,255) → (255,164,255); pixels (128,128,128) → (128,128,128).
- Mode 0, len=8, random data/strb, out_ready_i toggling every other cycle → output identical to the input in order, no loss or duplication, data stable while stalled.
- len=0 start → no in_ready_o, done_o pulses once, busy_o stays 0; start_i during a len=4 job → ignored, exactly 4 beats out.
- Continuous valid with out_ready_i=1 for len=16 → 16 beats in 16+PIPE_STAGES cycles; a 17th offered beat is never accepted.
- rst_i asserted after 3 of 6 beats → all outputs 0 immediately; a new job with len=2 afterwards completes normally.
